// File: rtl/bank_distributor_pkg.sv
// Shared width derivations and the global word -> (bank, bank address) mapping
// for the bank distributor.
package bank_distributor_pkg;

    function automatic int global_addr_bits(input int depth, input int n);
        return $clog2(depth * n);
    endfunction

    function automatic int bank_addr_bits(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int bank_idx_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Words are interleaved across banks: consecutive words land in consecutive banks.
    function automatic int word_bank(input int w, input int n);
        return w % n;
    endfunction

    function automatic int word_bank_addr(input int w, input int n);
        return w / n;
    endfunction

endpackage

// File: rtl/bank_distributor_if.sv
// Request/bank-write bundle between a lane source and the bank distributor.
interface bank_distributor_if
    import bank_distributor_pkg::*;
#(
    parameter int CHANNEL_NUMBER    = 3,
    parameter int CHANNEL_BANDWIDTH = 8,
    parameter int BANK_DEPTH        = 12
);
    localparam int N   = CHANNEL_NUMBER;
    localparam int BW  = CHANNEL_BANDWIDTH;
    localparam int GAB = global_addr_bits(BANK_DEPTH, CHANNEL_NUMBER);
    localparam int BAB = bank_addr_bits(BANK_DEPTH);

    logic              I_valid_in;
    logic [N*BW-1:0]   I_data_in;
    logic [GAB-1:0]    I_address_in;
    logic [N*BW-1:0]   O_data_out;
    logic [N*BAB-1:0]  O_address_out;
    logic [N-1:0]      O_clk_out;

    modport master (
        output I_valid_in, I_data_in, I_address_in,
        input  O_data_out, O_address_out, O_clk_out
    );

    modport slave (
        input  I_valid_in, I_data_in, I_address_in,
        output O_data_out, O_address_out, O_clk_out
    );

endinterface

// File: rtl/bank_distributor_address_mapper.sv
// Combinational per-lane target computation: wrapped global word, its bank and
// its address inside that bank.
module bank_address_mapper
    import bank_distributor_pkg::*;
#(
    parameter int CHANNEL_NUMBER = 3,
    parameter int BANK_DEPTH     = 12,
    parameter int GAB            = global_addr_bits(BANK_DEPTH, CHANNEL_NUMBER),
    parameter int BAB            = bank_addr_bits(BANK_DEPTH),
    parameter int BIB            = bank_idx_bits(CHANNEL_NUMBER)
) (
    input  logic [GAB-1:0] address,
    output logic           in_range,
    output logic [BIB-1:0] lane_bank [CHANNEL_NUMBER],
    output logic [BAB-1:0] lane_addr [CHANNEL_NUMBER]
);
    localparam int N     = CHANNEL_NUMBER;
    localparam int TOTAL = BANK_DEPTH * N;
    // One extra bit so both T and a+k (< 2T) are representable.
    localparam logic [GAB:0] TOTAL_W = (GAB+1)'(TOTAL);

    assign in_range = {1'b0, address} < TOTAL_W;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [GAB:0] sum;
            logic [GAB:0] wrapped;

            assign sum     = {1'b0, address} + (GAB+1)'(gi);
            assign wrapped = (sum >= TOTAL_W) ? (sum - TOTAL_W) : sum;

            assign lane_bank[gi] = BIB'(word_bank(int'(wrapped), N));
            assign lane_addr[gi] = BAB'(word_bank_addr(int'(wrapped), N));
        end
    endgenerate

endmodule

// File: rtl/bank_distributor.sv
// Routes N incoming lanes to N interleaved banks via a rotation and registers
// per-bank data, address and a one-cycle write strobe.
module bank_distributor
    import bank_distributor_pkg::*;
#(
    parameter int CHANNEL_NUMBER    = 3,
    parameter int CHANNEL_BANDWIDTH = 8,
    parameter int BANK_DEPTH        = 12
) (
    input  logic               I_clk_in,
    input  logic               I_rst_n,
    bank_distributor_if.slave  bus
);
    localparam int N   = CHANNEL_NUMBER;
    localparam int BW  = CHANNEL_BANDWIDTH;
    localparam int GAB = global_addr_bits(BANK_DEPTH, N);
    localparam int BAB = bank_addr_bits(BANK_DEPTH);
    localparam int BIB = bank_idx_bits(N);

    logic           in_range;
    logic           accept;
    logic [BIB-1:0] lane_bank [N];
    logic [BAB-1:0] lane_addr [N];
    logic [BW-1:0]  lane_data [N];

    logic [BW-1:0]  data_reg  [N];
    logic [BW-1:0]  data_next [N];
    logic [BAB-1:0] addr_reg  [N];
    logic [BAB-1:0] addr_next [N];
    logic [N-1:0]   strobe_reg;

    bank_address_mapper #(
        .CHANNEL_NUMBER (N),
        .BANK_DEPTH     (BANK_DEPTH),
        .GAB            (GAB),
        .BAB            (BAB),
        .BIB            (BIB)
    ) u_mapper (
        .address   (bus.I_address_in),
        .in_range  (in_range),
        .lane_bank (lane_bank),
        .lane_addr (lane_addr)
    );

    assign accept = bus.I_valid_in && in_range;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_io
            assign lane_data[gi]                    = bus.I_data_in[gi*BW +: BW];
            assign bus.O_data_out[gi*BW +: BW]      = data_reg[gi];
            assign bus.O_address_out[gi*BAB +: BAB] = addr_reg[gi];
        end
    endgenerate

    assign bus.O_clk_out = strobe_reg;

    // Lane-to-bank mapping is a rotation, so every bank is written by exactly one lane.
    always_comb begin
        data_next = data_reg;
        addr_next = addr_reg;
        for (int k = 0; k < N; k++) begin
            data_next[lane_bank[k]] = lane_data[k];
            addr_next[lane_bank[k]] = lane_addr[k];
        end
    end

    always_ff @(posedge I_clk_in) begin
        if (!I_rst_n) begin
            strobe_reg <= '0;
            for (int b = 0; b < N; b++) begin
                data_reg[b] <= '0;
                addr_reg[b] <= '0;
            end
        end else begin
            strobe_reg <= {N{accept}};
            if (accept) begin
                data_reg <= data_next;
                addr_reg <= addr_next;
            end
        end
    end

endmodule

// File: tb/tb_bank_distributor.sv
// Directed bench for bank_distributor with N=3, 8-bit lanes, 12 words per bank.
module tb_bank_distributor;
    localparam int N  = 3;
    localparam int BW = 8;
    localparam int BD = 12;
    localparam int T  = N * BD;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    logic [N+N*4+N*BW-1:0] got;
    logic [N+N*4+N*BW-1:0] exp;
    logic [N*BW-1:0]       hold_data;
    logic [N*4-1:0]        hold_addr;

    bank_distributor_if #(
        .CHANNEL_NUMBER(N), .CHANNEL_BANDWIDTH(BW), .BANK_DEPTH(BD)
    ) bus ();

    bank_distributor #(
        .CHANNEL_NUMBER(N), .CHANNEL_BANDWIDTH(BW), .BANK_DEPTH(BD)
    ) dut (
        .I_clk_in (clk),
        .I_rst_n  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference mapping: lane k goes to word (a+k) mod T, bank w mod 3, address w div 3.
    function automatic void model(input int a, input logic [23:0] din,
                                  output logic [23:0] ed, output logic [11:0] ea);
        int w;
        int b;
        ed = '0;
        ea = '0;
        for (int k = 0; k < N; k++) begin
            w = (a + k) % T;
            b = w % N;
            ed[b*8 +: 8] = din[k*8 +: 8];
            ea[b*4 +: 4] = 4'(w / N);
        end
    endfunction

    task automatic drive(input logic v, input int a, input logic [23:0] d);
        bus.I_valid_in   = v;
        bus.I_address_in = 6'(a);
        bus.I_data_in    = d;
        @(posedge clk);
        #1;
        got = {bus.O_clk_out, bus.O_address_out, bus.O_data_out};
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 0, 24'h0055FF);
            exp = '0;
            if (got !== exp) begin
                $display("FAIL reset_hold%0d: got %h required %h", i, got, exp);
                n_err++;
            end
            n_vec++;
            $display("reset cycle %0d outputs=%h", i, got);
        end
        rst_n = 1'b1;
        drive(1'b0, 0, 24'h0055FF);
        exp = '0;
        if (got !== exp) begin
            $display("FAIL reset_release_idle: got %h required %h", got, exp);
            n_err++;
        end
        n_vec++;
        $display("release idle outputs=%h", got);
    endtask

    task automatic test_basic;
        logic [23:0] lanes;
        logic [23:0] vd [3];
        logic [11:0] va [3];
        int          aa [3];
        lanes = 24'h0055FF;
        aa[0] = 0;  vd[0] = 24'h0055FF; va[0] = 12'h000;
        aa[1] = 1;  vd[1] = 24'h55FF00; va[1] = 12'h001;
        aa[2] = 34; vd[2] = 24'h55FF00; va[2] = 12'hBB0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, aa[i], lanes);
            exp = {3'b111, va[i], vd[i]};
            if (got !== exp) begin
                $display("FAIL basic_a%0d: got %h required %h", aa[i], got, exp);
                n_err++;
            end
            n_vec++;
            $display("basic a=%0d outputs=%h", aa[i], got);
        end
        hold_data = vd[2];
        hold_addr = va[2];
    endtask

    task automatic test_invalid;
        int aa [3];
        aa[0] = 0; aa[1] = 5; aa[2] = 35;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, aa[i], 24'hA5A5A5);
            exp = {3'b000, hold_addr, hold_data};
            if (got !== exp) begin
                $display("FAIL invalid_a%0d: got %h required %h", aa[i], got, exp);
                n_err++;
            end
            n_vec++;
            $display("invalid a=%0d outputs=%h", aa[i], got);
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] d;
        logic [23:0] ed;
        logic [11:0] ea;
        for (int a = 0; a < 12; a++) begin
            d = {8'(8'h20 + a), 8'(8'h10 + a), 8'(a)};
            model(a, d, ed, ea);
            drive(1'b1, a, d);
            exp = {3'b111, ea, ed};
            if (got !== exp) begin
                $display("FAIL sweep_a%0d: got %h required %h", a, got, exp);
                n_err++;
            end
            n_vec++;
            $display("sweep a=%0d outputs=%h", a, got);
            hold_data = ed;
            hold_addr = ea;
        end
    endtask

    task automatic test_out_of_range;
        for (int a = 36; a < 64; a++) begin
            drive(1'b1, a, 24'h123456);
            exp = {3'b000, hold_addr, hold_data};
            if (got !== exp) begin
                $display("FAIL oor_a%0d: got %h required %h", a, got, exp);
                n_err++;
            end
            n_vec++;
            $display("out-of-range a=%0d outputs=%h", a, got);
        end
    endtask

    task automatic test_reset_mid_stream;
        drive(1'b1, 3, 24'h0055FF);
        exp = {3'b111, 12'h111, 24'h0055FF};
        if (got !== exp) begin
            $display("FAIL stream_a3: got %h required %h", got, exp);
            n_err++;
        end
        n_vec++;
        $display("stream a=3 outputs=%h", got);

        rst_n = 1'b0;
        drive(1'b1, 4, 24'h0055FF);
        exp = '0;
        if (got !== exp) begin
            $display("FAIL midreset: got %h required %h", got, exp);
            n_err++;
        end
        n_vec++;
        $display("mid-stream reset outputs=%h", got);

        rst_n = 1'b1;
        drive(1'b1, 0, 24'h0055FF);
        exp = {3'b111, 12'h000, 24'h0055FF};
        if (got !== exp) begin
            $display("FAIL post_release_a0: got %h required %h", got, exp);
            n_err++;
        end
        n_vec++;
        $display("post-release a=0 outputs=%h", got);

        drive(1'b0, 0, 24'h0055FF);
        exp = {3'b000, 12'h000, 24'h0055FF};
        if (got !== exp) begin
            $display("FAIL post_release_single: got %h required %h", got, exp);
            n_err++;
        end
        n_vec++;
        $display("post-release idle outputs=%h", got);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.I_valid_in   = 1'b0;
        bus.I_address_in = '0;
        bus.I_data_in    = '0;
        test_reset();
        test_basic();
        test_invalid();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bank_distributor.md
BANK_DISTRIBUTOR -- requirements
Module: bank_distributor

Interface
REQ-001 Parameter CHANNEL_NUMBER, default 3: number of data lanes and of output banks (N), >=2.
REQ-002 Parameter CHANNEL_BANDWIDTH, default 8: width in bits of one lane/word.
REQ-003 Parameter BANK_DEPTH, default 12: words per bank; derived GLOBAL_ADDR_BITS = clog2(BANK_DEPTH*N), BANK_ADDR_BITS = clog2(BANK_DEPTH).
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 I_clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-006 I_rst_n  input  1  synchronous active-low reset.
REQ-007 I_valid_in  input  1  high = write request this cycle.
REQ-008 I_data_in  input  N x CHANNEL_BANDWIDTH  lane k carries word for global word index a+k.
REQ-009 I_address_in  input  GLOBAL_ADDR_BITS  global word address a of lane 0.
REQ-010 O_data_out  output  N x CHANNEL_BANDWIDTH  per-bank write data.
REQ-011 O_address_out  output  N x BANK_ADDR_BITS  per-bank write address.
REQ-012 O_clk_out  output  N x 1  per-bank write strobe, active high, one cycle per write.

Function
REQ-013 Global word w SHALL map to bank (w mod N) at bank address (w div N); total space T = BANK_DEPTH*N words.
REQ-014 On a cycle with I_valid_in=1 and a < T, lane k SHALL target word w_k = (a+k) mod T (wrap-around at T).
REQ-015 For each lane k, bank b = w_k mod N SHALL receive O_data_out[b] = I_data_in[k] and O_address_out[b] = w_k div N; the mapping is a rotation, so every bank receives exactly one lane.
REQ-016 All N entries of O_clk_out SHALL pulse high for exactly the cycle after an accepted request (latency 1, registered outputs).
REQ-017 If I_valid_in=0 or a >= T, O_clk_out SHALL be all 0 next cycle and O_data_out/O_address_out SHALL hold previous values.
REQ-018 Back-to-back valid requests SHALL produce back-to-back strobes; no request is dropped or merged.
REQ-019 div/mod by N SHALL be by constant parameter, combinational, no multi-cycle divider.

Reset
REQ-020 While I_rst_n=0 at a rising edge, all O_data_out, O_address_out and O_clk_out SHALL become 0 the next cycle.
REQ-021 A request presented in a cycle with I_rst_n=0 SHALL be discarded; reset asserted mid-stream overrides any pending strobe.
REQ-022 First accepted request after reset release SHALL behave per REQ-014..016 with no extra latency.

Structure
REQ-023 Package bank_distributor_pkg SHALL hold the address-width derivation functions and the word->(bank, bank address) mapping function.
REQ-024 One sub-module bank_address_mapper SHALL compute, per lane, target bank and bank address (combinational); top level holds rotation mux and output registers.

Verification (N=3, BW=8, BANK_DEPTH=12, lanes FF/55/00)
REQ-025 a=0, valid -> next cycle: bank0=FF@0, bank1=55@0, bank2=00@0, O_clk_out=111.
REQ-026 a=1, valid -> bank0=00@1, bank1=FF@0, bank2=55@0, O_clk_out=111.
REQ-027 a=34, valid (wrap) -> bank1=FF@11, bank2=55@11, bank0=00@0, O_clk_out=111.
REQ-028 Sweep a=0..11 back-to-back -> 12 consecutive strobe cycles, each matching REQ-015 model; a=36..63 -> no strobes, outputs hold.
REQ-029 valid=0 for any a -> O_clk_out=000, outputs unchanged.
REQ-030 Reset asserted during a valid stream -> next cycle all outputs 0, first post-release request strobes after exactly 1 cycle.
